instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, byte-address width of the emitted instruction stream.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  synchronous pulse: restart the program at address 0.
REQ-005 SHALL have port in_valid  input  1  instruction request valid.
REQ-006 SHALL have port in_ready  output  1  request accepted when in_valid && in_ready.
REQ-007 SHALL have port in_class  input  3  0=LOAD, 1=STORE, 2=BRANCH, 3=ITYPE, 4=RTYPE, 5=JAL; 6-7 illegal.
REQ-008 SHALL have ports rd, rs1, rs2  input  5 each  register indices.
REQ-009 SHALL have port funct3  input  3  funct3 field.
REQ-010 SHALL have port funct7b5  input  1  bit 30 for RTYPE and ITYPE shifts.
REQ-011 SHALL have port imm  input  32  signed immediate, byte offset for BRANCH and JAL.
REQ-012 SHALL have port out_valid  output  1  encoded word valid.
REQ-013 SHALL have port out_ready  input  1  consumer accepts when out_valid && out_ready.
REQ-014 SHALL have port out_instr  output  32  encoded RV32I word.
REQ-015 SHALL have port out_addr  output  ADDR_W  byte address of out_instr.
REQ-016 SHALL have port err  output  1  one-cycle pulse on a rejected request.

Function
REQ-017 SHALL encode opcodes: LOAD 0000011, STORE 0100011, BRANCH 1100011, ITYPE 0010011, RTYPE 0110011, JAL 1101111.
REQ-018 LOAD: {imm[11:0], rs1, funct3, rd, op}.
REQ-019 ITYPE: as LOAD, except funct3 001/101 use {0, funct7b5, 00000, imm[4:0]} in bits 31:20.
REQ-020 STORE: {imm[11:5], rs2, rs1, funct3, imm[4:0], op}.
REQ-021 BRANCH: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op}.
REQ-022 RTYPE: {0, funct7b5, 00000, rs2, rs1, funct3, rd, op}.
REQ-023 JAL: {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}.
REQ-024 SHALL reject the request when the class is illegal, or when imm does not fit the field (LOAD/STORE/non-shift ITYPE: signed 12 bits; shift ITYPE: 0..31; BRANCH: signed 13 bits and even; JAL: signed 21 bits and even).
REQ-025 Rejected request: SHALL be consumed, produce no output and leave out_addr unchanged; err SHALL be high exactly the following cycle.
REQ-026 in_ready SHALL equal (!out_valid || out_ready) && !start.
REQ-027 Latency: an accepted legal request SHALL appear on out_valid/out_instr the next cycle.
REQ-028 out_instr and out_addr SHALL hold stable while out_valid && !out_ready.
REQ-029 out_addr SHALL advance by 4 on each output handshake, modulo 2^ADDR_W (wraps to 0).
REQ-030 Output handshake and new acceptance in the same cycle SHALL give back-to-back words with no bubble.
REQ-031 start SHALL clear out_valid, set the next address to 0 and block acceptance that cycle; start overrides a simultaneous output handshake.

Reset
REQ-032 rst SHALL asynchronously force out_valid=0, out_instr=0, out_addr=0, err=0.
REQ-033 A word pending at reset SHALL be discarded; the first word after reset SHALL be at address 0.

Structure
REQ-034 Opcode constants and the in_class encodings SHALL live in the shared package riscv_pkg, reused by the main decoder.
REQ-035 Immediate packing and range checking SHALL be a combinational sub-module imm_packer (in_class, funct3, imm -> packed fields, imm_ok).
REQ-036 Sequential logic (output register, address counter, err pulse) SHALL be in instr_encoder only.

Verification
REQ-037 ITYPE rd=1 rs1=0 f3=0 imm=5 after reset -> out_instr 0x00500093, out_addr 0, one cycle later.
REQ-038 RTYPE rd=3 rs1=1 rs2=2 f3=0 b5=0, then STORE rs1=1 rs2=2 f3=2 imm=8 -> 0x002081B3 and 0x0020A423 at addresses 0 and 4, back-to-back.
REQ-039 BRANCH rs1=1 rs2=2 f3=0 imm=-4 -> 0xFE208EE3; JAL rd=1 imm=8 -> 0x008000EF.
REQ-040 BRANCH imm=3, then class 7 -> no out_valid, err pulses once per request, out_addr unchanged.
REQ-041 Hold out_ready=0 for 5 cycles with a word pending -> in_ready=0, out_instr/out_addr stable; release -> single handshake.
REQ-042 ADDR_W=4: 5 words -> addresses 0,4,8,12,0; start mid-stream -> pending word dropped, next word at address 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I encoding constants: request class codes, major opcodes and
// per-class field-usage helpers used by the encoder and its immediate packer.
package riscv_pkg;

  typedef enum logic [2:0] {
    CLS_LOAD   = 3'd0,
    CLS_STORE  = 3'd1,
    CLS_BRANCH = 3'd2,
    CLS_ITYPE  = 3'd3,
    CLS_RTYPE  = 3'd4,
    CLS_JAL    = 3'd5
  } instr_class_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  function automatic logic class_legal(input logic [2:0] cls);
    class_legal = (cls <= 3'd5);
  endfunction

  // ITYPE funct3 001 (SLLI) and 101 (SRLI/SRAI) carry a shamt, not a 12-bit immediate.
  function automatic logic is_shift(input logic [2:0] f3);
    is_shift = (f3 == 3'b001) || (f3 == 3'b101);
  endfunction

  function automatic logic [6:0] class_opcode(input logic [2:0] cls);
    case (cls)
      CLS_LOAD:   class_opcode = OP_LOAD;
      CLS_STORE:  class_opcode = OP_STORE;
      CLS_BRANCH: class_opcode = OP_BRANCH;
      CLS_ITYPE:  class_opcode = OP_ITYPE;
      CLS_RTYPE:  class_opcode = OP_RTYPE;
      CLS_JAL:    class_opcode = OP_JAL;
      default:    class_opcode = 7'b0000000;
    endcase
  endfunction

  function automatic logic uses_rd(input logic [2:0] cls);
    uses_rd = (cls == CLS_LOAD) || (cls == CLS_ITYPE) || (cls == CLS_RTYPE) || (cls == CLS_JAL);
  endfunction

  function automatic logic uses_rs1(input logic [2:0] cls);
    uses_rs1 = (cls <= 3'd4);
  endfunction

  function automatic logic uses_rs2(input logic [2:0] cls);
    uses_rs2 = (cls == CLS_STORE) || (cls == CLS_BRANCH) || (cls == CLS_RTYPE);
  endfunction

endpackage

// File: rtl/imm_packer.sv
// Combinational immediate scatter and range check: places imm bits at their
// instruction positions for the given class and flags whether imm fits.
module imm_packer
  import riscv_pkg::*;
(
  input  logic [2:0]  in_class,
  input  logic [2:0]  funct3,
  input  logic [31:0] imm,
  output logic [31:0] imm_bits,
  output logic        imm_ok
);

  logic fits_s12;
  logic fits_s13;
  logic fits_s21;
  logic fits_shamt;

  // A value fits n signed bits when everything from bit n-1 upward is a pure sign extension.
  assign fits_s12   = (&imm[31:11]) || !(|imm[31:11]);
  assign fits_s13   = (&imm[31:12]) || !(|imm[31:12]);
  assign fits_s21   = (&imm[31:20]) || !(|imm[31:20]);
  assign fits_shamt = !(|imm[31:5]);

  always_comb begin
    imm_bits = '0;
    imm_ok   = 1'b0;
    case (in_class)
      CLS_LOAD: begin
        imm_bits[31:20] = imm[11:0];
        imm_ok          = fits_s12;
      end
      CLS_ITYPE: begin
        if (is_shift(funct3)) begin
          imm_bits[24:20] = imm[4:0];
          imm_ok          = fits_shamt;
        end else begin
          imm_bits[31:20] = imm[11:0];
          imm_ok          = fits_s12;
        end
      end
      CLS_STORE: begin
        imm_bits[31:25] = imm[11:5];
        imm_bits[11:7]  = imm[4:0];
        imm_ok          = fits_s12;
      end
      CLS_BRANCH: begin
        imm_bits[31]    = imm[12];
        imm_bits[30:25] = imm[10:5];
        imm_bits[11:8]  = imm[4:1];
        imm_bits[7]     = imm[11];
        imm_ok          = fits_s13 && !imm[0];
      end
      CLS_RTYPE: begin
        imm_ok = 1'b1;
      end
      CLS_JAL: begin
        imm_bits[31]    = imm[20];
        imm_bits[30:21] = imm[10:1];
        imm_bits[20]    = imm[11];
        imm_bits[19:12] = imm[19:12];
        imm_ok          = fits_s21 && !imm[0];
      end
      default: begin
        imm_ok = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: one registered output word, accepted request shows next cycle;
// accepts only while the output slot is empty or draining; start/reset drop the pending word.
module instr_encoder
  import riscv_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_class,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic              funct7b5,
  input  logic [31:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err
);

  logic              out_valid_q, out_valid_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_q, err_d;

  logic [31:0] imm_bits;
  logic        imm_ok;
  logic [31:0] enc_word;
  logic        legal;
  logic        accept;
  logic        out_hs;
  logic        use_b5;

  imm_packer u_imm_packer (
    .in_class (in_class),
    .funct3   (funct3),
    .imm      (imm),
    .imm_bits (imm_bits),
    .imm_ok   (imm_ok)
  );

  assign in_ready = (!out_valid_q || out_ready) && !start;
  assign accept   = in_valid && in_ready;
  assign out_hs   = out_valid_q && out_ready && !start;
  assign legal    = class_legal(in_class) && imm_ok;
  assign use_b5   = (in_class == CLS_RTYPE) || ((in_class == CLS_ITYPE) && is_shift(funct3));

  // Register and funct fields overlay the zero gaps left by the immediate scatter.
  always_comb begin
    enc_word      = imm_bits;
    enc_word[6:0] = class_opcode(in_class);
    if (uses_rd(in_class))  enc_word[11:7]  = rd;
    if (uses_rs1(in_class)) enc_word[14:12] = funct3;
    if (uses_rs1(in_class)) enc_word[19:15] = rs1;
    if (uses_rs2(in_class)) enc_word[24:20] = rs2;
    if (use_b5)             enc_word[30]    = funct7b5;
  end

  // out_addr always names the slot of the next word to be emitted.
  always_comb begin
    out_valid_d = out_valid_q;
    instr_d     = instr_q;
    addr_d      = addr_q;
    err_d       = 1'b0;
    if (out_hs) begin
      out_valid_d = 1'b0;
      addr_d      = addr_q + ADDR_W'(4);
    end
    if (accept) begin
      if (legal) begin
        out_valid_d = 1'b1;
        instr_d     = enc_word;
      end else begin
        err_d = 1'b1;
      end
    end
    if (start) begin
      out_valid_d = 1'b0;
      addr_d      = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      instr_q     <= '0;
      addr_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      instr_q     <= instr_d;
      addr_q      <= addr_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_instr = instr_q;
  assign out_addr  = addr_q;
  assign err       = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder (ADDR_W=4): directed encodings plus randomized
// requests checked against an arithmetic reference encoder.
`timescale 1ns/1ps
module tb_instr_encoder;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_class;
  logic [4:0]    rd, rs1, rs2;
  logic [2:0]    funct3;
  logic          funct7b5;
  logic [31:0]   imm;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_instr;
  logic [AW-1:0] out_addr;
  logic          err;

  typedef struct packed {
    logic [31:0]   instr;
    logic [AW-1:0] addr;
  } exp_t;

  exp_t exp_q[$];
  int   err_q[$];
  int   hs_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   model_addr = 0;
  int   rdy_mode = 1;
  bit   eflag;
  int   bnd[14] = '{2047, -2048, 2048, -2049, 31, 32, 4094, 4095, -4096, -4098,
                    1048574, -1048576, 1048576, 0};

  instr_encoder #(.ADDR_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_class  (in_class),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .funct3    (funct3),
    .funct7b5  (funct7b5),
    .imm       (imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_addr  (out_addr),
    .err       (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h, required %h", nm, cyc, act, expv);
    end
  endfunction

  function automatic int unsigned bits(input int unsigned u, input int lo, input int n);
    return (u >> lo) & ((32'd1 << n) - 1);
  endfunction

  // Reference encoder built from the field tables with plain arithmetic.
  function automatic void model(input int cls, input int rdv, input int r1, input int r2,
                                input int f3, input int b5, input int iv,
                                output bit ok, output logic [31:0] w);
    int unsigned u = iv;
    int unsigned x = 0;
    ok = 1'b1;
    case (cls)
      0, 3: begin
        if (cls == 3 && (f3 == 1 || f3 == 5)) begin
          ok = (iv >= 0) && (iv <= 31);
          x  = (b5 << 30) | (bits(u, 0, 5) << 20);
        end else begin
          ok = (iv >= -2048) && (iv <= 2047);
          x  = bits(u, 0, 12) << 20;
        end
        x = x | (r1 << 15) | (f3 << 12) | (rdv << 7) | ((cls == 0) ? 'h03 : 'h13);
      end
      1: begin
        ok = (iv >= -2048) && (iv <= 2047);
        x  = (bits(u, 5, 7) << 25) | (r2 << 20) | (r1 << 15) | (f3 << 12) |
             (bits(u, 0, 5) << 7) | 'h23;
      end
      2: begin
        ok = (iv >= -4096) && (iv <= 4095) && (iv % 2 == 0);
        x  = (bits(u, 12, 1) << 31) | (bits(u, 5, 6) << 25) | (r2 << 20) | (r1 << 15) |
             (f3 << 12) | (bits(u, 1, 4) << 8) | (bits(u, 11, 1) << 7) | 'h63;
      end
      4: begin
        x = (b5 << 30) | (r2 << 20) | (r1 << 15) | (f3 << 12) | (rdv << 7) | 'h33;
      end
      5: begin
        ok = (iv >= -1048576) && (iv < 1048576) && (iv % 2 == 0);
        x  = (bits(u, 20, 1) << 31) | (bits(u, 1, 10) << 21) | (bits(u, 11, 1) << 20) |
             (bits(u, 12, 8) << 12) | (rdv << 7) | 'h6f;
      end
      default: ok = 1'b0;
    endcase
    w = x;
  endfunction

  task automatic send(input int cls, input int rdv, input int r1, input int r2, input int f3,
                      input int b5, input int iv, input bit use_lit, input logic [31:0] lit);
    bit          ok;
    logic [31:0] w;
    int          waited = 0;
    bit          got = 1'b0;
    model(cls, rdv, r1, r2, f3, b5, iv, ok, w);
    if (use_lit) begin
      ok = 1'b1;
      w  = lit;
    end
    in_class = 3'(cls);
    rd       = 5'(rdv);
    rs1      = 5'(r1);
    rs2      = 5'(r2);
    funct3   = 3'(f3);
    funct7b5 = 1'(b5);
    imm      = iv;
    in_valid = 1'b1;
    while (!got && waited < 50) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
      else waited++;
    end
    if (!got) begin
      in_valid = 1'b0;
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: in_ready stayed 0 for 50 cycles, required 1");
      @(posedge clk);
      #1;
      return;
    end
    @(posedge clk);
    #1;
    if (ok) begin
      exp_q.push_back('{instr: w, addr: AW'(model_addr)});
      model_addr = (model_addr + 4) % (1 << AW);
    end else begin
      err_q.push_back(cyc);
    end
    in_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    model_addr = 0;
    start = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_addr", 32'(out_addr), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    exp_q.delete();
    err_q.delete();
    model_addr = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: %0d words outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Output consumer; updates later than the driver so mode changes are seen next cycle.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       out_ready = ($urandom_range(0, 3) != 0);
        1:       out_ready = 1'b1;
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: compares DUT outputs against the scoreboard every cycle.
  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready", 32'(in_ready), 32'((exp_q.size() == 0 || out_ready) && !start));
      if (!start) begin
        chk("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
        if (exp_q.size() > 0) begin
          chk("out_instr", out_instr, exp_q[0].instr);
          chk("out_addr", 32'(out_addr), 32'(exp_q[0].addr));
          if (out_ready) begin
            void'(exp_q.pop_front());
            hs_q.push_back(cyc);
          end
        end
      end
      eflag = (err_q.size() > 0) && (err_q[0] == cyc);
      if (eflag) void'(err_q.pop_front());
      chk("err", 32'(err), 32'(eflag));
    end
  end

  initial begin
    int cls, iv, sel;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_class = '0;
    rd = '0; rs1 = '0; rs2 = '0; funct3 = '0; funct7b5 = 1'b0; imm = '0;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_addr", 32'(out_addr), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);

    send(3, 1, 0, 0, 0, 0, 5, 1'b1, 32'h00500093);
    drain();

    do_start();
    hs_q.delete();
    send(4, 3, 1, 2, 0, 0, 0, 1'b1, 32'h002081B3);
    send(1, 0, 1, 2, 2, 0, 8, 1'b1, 32'h0020A423);
    drain();
    chk("b2b_gap", (hs_q.size() == 2) ? 32'(hs_q[1] - hs_q[0]) : 32'hFFFFFFFF, 32'd1);

    send(2, 0, 1, 2, 0, 0, -4, 1'b1, 32'hFE208EE3);
    send(5, 1, 0, 0, 0, 0, 8, 1'b1, 32'h008000EF);
    drain();

    send(2, 0, 1, 2, 0, 0, 3, 1'b0, 32'd0);
    send(7, 1, 1, 1, 0, 0, 0, 1'b0, 32'd0);
    idle(2);
    send(0, 4, 5, 0, 2, 0, -1, 1'b0, 32'd0);
    drain();

    rdy_mode = 2;
    idle(1);
    send(4, 7, 8, 9, 7, 1, 0, 1'b0, 32'd0);
    idle(5);
    rdy_mode = 1;
    drain();

    do_start();
    for (int i = 0; i < 5; i++) send(3, i + 1, i, 0, 0, 0, 10 * i, 1'b0, 32'd0);
    drain();

    rdy_mode = 2;
    idle(1);
    send(3, 2, 2, 0, 5, 1, 17, 1'b0, 32'd0);
    idle(2);
    do_start();
    rdy_mode = 1;
    send(3, 3, 3, 0, 1, 0, 31, 1'b0, 32'd0);
    drain();

    rdy_mode = 2;
    idle(1);
    send(1, 0, 6, 7, 2, 0, -2048, 1'b0, 32'd0);
    idle(1);
    do_reset();
    rdy_mode = 1;
    send(5, 31, 0, 0, 0, 0, -1048576, 1'b0, 32'd0);
    drain();

    rdy_mode = 0;
    for (int i = 0; i < 300; i++) begin
      cls = $urandom_range(0, 7);
      sel = $urandom_range(0, 2);
      if (sel == 0) iv = int'($urandom_range(0, 80)) - 40;
      else if (sel == 1) iv = bnd[$urandom_range(0, 13)];
      else iv = int'($urandom);
      send(cls, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
           $urandom_range(0, 7), $urandom_range(0, 1), iv, 1'b0, 32'd0);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      if ($urandom_range(0, 39) == 0) do_start();
    end
    rdy_mode = 1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
